// File: rtl/fetch_control_if.sv
// ============================================================================
// Module      : fetch_control_if
// Description : Bus bundle between the instruction fetch controller and its
//               memory / decoder neighbours.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_control_if;
    logic       RUN;
    logic       MEM_RDY;
    logic       DEC_ACK;
    logic       PC_LD;
    logic [7:0] PC_IN;
    logic [7:0] ADDR;
    logic       MEM_RD;
    logic [3:0] LATCH;
    logic       INST_VALID;
    logic [7:0] PC_OUT;

    modport master (
        input  RUN, MEM_RDY, DEC_ACK, PC_LD, PC_IN,
        output ADDR, MEM_RD, LATCH, INST_VALID, PC_OUT
    );

    modport slave (
        output RUN, MEM_RDY, DEC_ACK, PC_LD, PC_IN,
        input  ADDR, MEM_RD, LATCH, INST_VALID, PC_OUT
    );
endinterface

`default_nettype wire

// File: rtl/fetch_control.sv
// ============================================================================
// Module      : fetch_control
// Description : Fetches a 4-byte instruction one byte at a time and strobes
//               each byte into the fetch datapath.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_control #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  wire              CLK,
    input  wire              CLR_B,
    fetch_control_if.master  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RD    = 2'd1;
    localparam logic [1:0] c_LAT   = 2'd2;
    localparam logic [1:0] c_VALID = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;
    logic [7:0] r_pc;
    logic [7:0] w_pc_nxt;
    logic       r_mem_rd;
    logic [3:0] r_latch;
    logic       r_inst_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        case (r_state)
            c_IDLE: begin
                if (bus.PC_LD) begin
                    w_pc_nxt = bus.PC_IN;
                end
                if (bus.RUN) begin
                    w_state_nxt = c_RD;
                    w_cnt_nxt   = 2'd0;
                end
            end
            c_RD: begin
                if (bus.MEM_RDY) begin
                    w_state_nxt = c_LAT;
                end
            end
            c_LAT: begin
                // PC wraps modulo 256 with no stall
                w_pc_nxt    = r_pc + 8'd1;
                w_cnt_nxt   = r_cnt + 2'd1;
                w_state_nxt = (r_cnt == 2'd3) ? c_VALID : c_RD;
            end
            c_VALID: begin
                if (bus.DEC_ACK) begin
                    if (bus.PC_LD) begin
                        w_pc_nxt = bus.PC_IN;
                    end
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = bus.RUN ? c_RD : c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Strobes are precomputed from the next state so every output is a flop
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            r_state      <= c_IDLE;
            r_cnt        <= 2'd0;
            r_pc         <= RESET_PC;
            r_mem_rd     <= 1'b0;
            r_latch      <= 4'b0000;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pc         <= w_pc_nxt;
            r_mem_rd     <= (w_state_nxt == c_RD) || (w_state_nxt == c_LAT);
            r_latch      <= (w_state_nxt == c_LAT) ? (4'b0001 << w_cnt_nxt) : 4'b0000;
            r_inst_valid <= (w_state_nxt == c_VALID);
        end
    end

    assign bus.ADDR       = r_pc;
    assign bus.PC_OUT     = r_pc;
    assign bus.MEM_RD     = r_mem_rd;
    assign bus.LATCH      = r_latch;
    assign bus.INST_VALID = r_inst_valid;

endmodule

`default_nettype wire

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter RESET_PC, default 8'h00, SHALL be the PC value loaded on reset.
REQ-002 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 CLR_B  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 RUN  input  1  SHALL be the fetch enable: 1 = fetch continuously, 0 = stop at the next instruction boundary.
REQ-005 MEM_RDY  input  1  SHALL be the memory data-ready flag; the memory SHALL hold DI stable while MEM_RD=1.
REQ-006 DEC_ACK  input  1  SHALL be the downstream acknowledge that the assembled instruction is consumed.
REQ-007 PC_LD  input  1  SHALL request a PC load from PC_IN.
REQ-008 PC_IN  input  8  SHALL be the branch/jump target byte address.
REQ-009 ADDR  output  8  SHALL be the memory byte address, always equal to PC_OUT.
REQ-010 MEM_RD  output  1  SHALL be the memory read request.
REQ-011 LATCH  output  4  SHALL be one-hot capture strobes to the four byte registers of the fetch datapath; bit n SHALL capture instruction byte n.
REQ-012 INST_VALID  output  1  SHALL indicate that all four instruction bytes are latched.
REQ-013 PC_OUT  output  8  SHALL be the current program counter.

Function
REQ-014 All outputs SHALL be driven from registers; no combinational input-to-output path.
REQ-015 FSM states SHALL be IDLE, RD, LAT, VALID; a 2-bit byte counter CNT SHALL track the byte being fetched.
REQ-016 IDLE: all strobes are 0; RUN=1 -> RD with CNT=0; RUN=0 -> stay.
REQ-017 RD: MEM_RD=1; MEM_RDY=0 -> stay (unbounded wait); MEM_RDY=1 -> LAT.
REQ-018 LAT: MEM_RD=1 and LATCH[CNT]=1 for exactly one cycle; on exit PC <= PC+1 and CNT <= CNT+1.
REQ-019 LAT exit: CNT=3 -> VALID; otherwise -> RD.
REQ-020 VALID: INST_VALID=1, MEM_RD=0, LATCH=0; the block SHALL hold in VALID until DEC_ACK=1.
REQ-021 VALID with DEC_ACK=1: RUN=1 -> RD; RUN=0 -> IDLE. CNT SHALL be 0 on exit.
REQ-022 PC_LD SHALL be honoured only in IDLE, or in VALID coincident with DEC_ACK=1; PC <= PC_IN, and PC_LD SHALL take priority over the increment. PC_LD SHALL be ignored in RD and LAT.
REQ-023 PC SHALL be 8-bit modulo: 8'hFF + 1 = 8'h00, with no flag and no stall.
REQ-024 RUN deasserted in RD or LAT SHALL NOT abort the fetch; the current instruction SHALL complete through VALID.
REQ-025 With MEM_RDY held at 1, a back-to-back instruction period SHALL be 9 cycles (4x(RD+LAT) + 1 VALID with immediate ack).
REQ-026 LATCH SHALL never have more than one bit set, and SHALL never be set outside LAT.
REQ-027 DEC_ACK outside VALID SHALL be ignored.

Reset
REQ-028 CLR_B=0 SHALL immediately, without waiting for CLK, force: state IDLE, CNT=0, PC_OUT=ADDR=RESET_PC, MEM_RD=0, LATCH=4'b0000, INST_VALID=0.
REQ-029 Reset asserted mid-fetch SHALL drop any LATCH strobe in the same instant; partially latched bytes SHALL be discarded (the datapath is cleared by the same CLR_B).
REQ-030 After CLR_B rises, the first possible RD SHALL occur on the first CLK edge that samples RUN=1.

Verification
REQ-031 Reset, RUN=1, MEM_RDY=1, DEC_ACK=1 -> ADDR sequence 00,00,01,01,02,02,03,03; LATCH 0001,0010,0100,1000 in cycles 2,4,6,8; INST_VALID=1 in cycle 9; the next RD at ADDR=04.
REQ-032 MEM_RDY held at 0 for 3 cycles during byte 1 -> RD holds ADDR=01 and MEM_RD=1 for 4 cycles; LATCH=0010 follows once; the period becomes 12 cycles.
REQ-033 In VALID, DEC_ACK=1 with PC_LD=1 and PC_IN=8'h40 -> next RD at ADDR=40; the same PC_LD applied during RD is ignored.
REQ-034 PC_IN=8'hFE loaded, run one instruction -> ADDR FE,FF,00,01; INST_VALID asserted; PC_OUT ends at 02.
REQ-035 CLR_B pulsed low during LAT of byte 2 -> LATCH=0, MEM_RD=0, PC_OUT=RESET_PC asynchronously; after release, the fetch restarts at byte 0.
REQ-036 RUN dropped during byte 1 -> the instruction completes; after DEC_ACK the block sits in IDLE with MEM_RD=0 and PC_OUT=04.
